// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register-file geometry, the arbiter state
// encoding and the write-request record passed between arbiter stages.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_BOOST  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_write_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set on load issue,
// cleared on load completion, and a decode-stage stall lookup.
module rf_scoreboard
  import riscv_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   busy
);

  localparam logic [NUM_REGS-1:0] X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_d;

  // Set is applied after clear so a same-cycle issue to the same rd keeps it pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd] = 1'b1;
    busy_d = ((busy & ~clr_mask) | set_mask) & X0_MASK;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= busy_d;
    end
  end

  assign stall = busy[rs1_addr] | busy[rs2_addr];

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter for writeback, load completion and debug
// writers, with load anti-starvation boost. Debug port enabled by RF_ARB_DEBUG_EN.
module rf_write_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic                  dbg_valid,
  output logic                  dbg_ready,
  input  logic [REG_ADDR_W-1:0] dbg_rd,
  input  logic [XLEN-1:0]       dbg_data,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  stall,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [NUM_REGS-1:0]   busy,
  output arb_state_e            arb_state
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             grant_wb, grant_ld, grant_dbg;
  rf_write_t        wr_sel;

  // Handshake: each ready is a pure function of the valids and current state;
  // a transfer occurs on any cycle where valid && ready, and at most one ready is high.
  always_comb begin
    grant_ld = reset_n && ld_valid && ((state_q == ARB_BOOST) || !wb_valid);
    grant_wb = reset_n && wb_valid && !grant_ld;
`ifdef RF_ARB_DEBUG_EN
    grant_dbg = reset_n && dbg_valid && !wb_valid && !ld_valid;
`else
    grant_dbg = 1'b0;
`endif
  end

  assign wb_ready  = grant_wb;
  assign ld_ready  = grant_ld;
  assign dbg_ready = grant_dbg;

`ifndef RF_ARB_DEBUG_EN
  logic unused_dbg;
  assign unused_dbg = ^{dbg_valid, dbg_rd, dbg_data};
`endif

  always_comb begin
    wr_sel = '0;
    if (grant_wb) begin
      wr_sel.valid = 1'b1;
      wr_sel.rd    = wb_rd;
      wr_sel.data  = wb_data;
    end else if (grant_ld) begin
      wr_sel.valid = 1'b1;
      wr_sel.rd    = ld_rd;
      wr_sel.data  = ld_data;
    end
`ifdef RF_ARB_DEBUG_EN
    else if (grant_dbg) begin
      wr_sel.valid = 1'b1;
      wr_sel.rd    = dbg_rd;
      wr_sel.data  = dbg_data;
    end
`endif
  end

  // Boost takes effect on the edge where the refusal count hits the limit,
  // so the load wins the very next cycle.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (!ld_valid || grant_ld) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + 1'b1;
    end
    case (state_q)
      ARB_NORMAL: if (starve_d == CNT_MAX) state_d = ARB_BOOST;
      ARB_BOOST:  if (grant_ld) state_d = ARB_NORMAL;
      default:    state_d = ARB_NORMAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_NORMAL;
      starve_q <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rf_wen   <= wr_sel.valid && (wr_sel.rd != '0);
      rf_waddr <= wr_sel.rd;
      rf_wdata <= wr_sel.data;
    end
  end

  assign arb_state = state_q;

  rf_scoreboard u_scoreboard (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_en   (ld_issue),
    .set_rd   (ld_issue_rd),
    .clr_en   (grant_ld),
    .clr_rd   (ld_rd),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .stall    (stall),
    .busy     (busy)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_rf_write_arbiter;
  import riscv_pkg::*;

  localparam int STARVE_LIMIT = 4;
  localparam int W = 1 + REG_ADDR_W + XLEN;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic                  wb_valid, wb_ready, ld_valid, ld_ready, dbg_valid, dbg_ready;
  logic [REG_ADDR_W-1:0] wb_rd, ld_rd, dbg_rd, ld_issue_rd, rs1_addr, rs2_addr, rf_waddr;
  logic [XLEN-1:0]       wb_data, ld_data, dbg_data, rf_wdata;
  logic                  ld_issue, stall, rf_wen;
  logic [NUM_REGS-1:0]   busy;
  arb_state_e            arb_state;

  rf_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .stall(stall),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .arb_state(arb_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [NUM_REGS-1:0] m_busy;
  int                  m_refused;
  bit                  m_boost;
  logic [W-1:0]        exp_q[$];
  logic                e_wb, e_ld, e_dbg, e_stall;
  logic [W-1:0]        e_prev;

  function automatic void model_reset();
    m_busy = '0;
    m_refused = 0;
    m_boost = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
  endfunction

  function automatic void model_eval();
    e_ld = ld_valid && (m_boost || !wb_valid);
    e_wb = wb_valid && !e_ld;
`ifdef RF_ARB_DEBUG_EN
    e_dbg = dbg_valid && !wb_valid && !ld_valid;
`else
    e_dbg = 1'b0;
`endif
    e_stall = m_busy[rs1_addr] | m_busy[rs2_addr];
    e_prev = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
  endfunction

  function automatic void model_commit();
    logic [REG_ADDR_W-1:0] rd = '0;
    logic [XLEN-1:0]       d = '0;
    bit                    g = 1'b1;
    if (e_wb) begin rd = wb_rd; d = wb_data; end
    else if (e_ld) begin rd = ld_rd; d = ld_data; end
    else if (e_dbg) begin rd = dbg_rd; d = dbg_data; end
    else g = 1'b0;
    exp_q.push_back({g && (rd != 0), rd, d});
    if (e_ld) m_busy[ld_rd] = 1'b0;
    if (ld_issue && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1'b1;
    if (ld_valid && !e_ld) m_refused++;
    else m_refused = 0;
    if (m_boost) begin
      if (e_ld) m_boost = 1'b0;
    end else if (m_refused >= STARVE_LIMIT) begin
      m_boost = 1'b1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    wb_valid = 0; ld_valid = 0; dbg_valid = 0; ld_issue = 0;
    wb_rd = 0; ld_rd = 0; dbg_rd = 0; ld_issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
    wb_data = 0; ld_data = 0; dbg_data = 0;
  endtask

  task automatic sample();
    @(negedge clock);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    wb_valid = 1; ld_valid = 1; dbg_valid = 1; wb_rd = 3; ld_rd = 4;
    reset_n = 0;
    repeat (2) @(negedge clock);
    n_checks++; if ({wb_ready, ld_ready, dbg_ready} !== 3'b000) begin n_fail++;
      $display("FAIL reset_ready got=%b exp=000", {wb_ready, ld_ready, dbg_ready}); end
    n_checks++; if (rf_wen !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin n_fail++;
      $display("FAIL reset_write got wen=%b addr=%0d data=%h exp 0", rf_wen, rf_waddr, rf_wdata); end
    n_checks++; if (busy !== '0 || arb_state !== ARB_NORMAL) begin n_fail++;
      $display("FAIL reset_state got busy=%h state=%0d exp busy=0 state=0", busy, arb_state); end
    idle_inputs();
    @(posedge clock); #1;
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_priority();
    wb_valid = 1; wb_rd = 5; wb_data = 32'h1234; ld_valid = 1; ld_rd = 6; ld_data = 32'hbeef;
    sample();
    n_checks++; if (wb_ready !== 1'b1 || ld_ready !== 1'b0) begin n_fail++;
      $display("FAIL priority_ready got wb=%b ld=%b exp wb=1 ld=0", wb_ready, ld_ready); end
    advance();
    idle_inputs();
    sample();
    n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin n_fail++;
      $display("FAIL priority_write got wen=%b addr=%0d data=%h exp 1/5/1234", rf_wen, rf_waddr, rf_wdata); end
    advance();
  endtask

  task automatic test_starvation();
    int first_ld = 0;
    for (int c = 1; c <= 6; c++) begin
      wb_valid = 1; wb_rd = REG_ADDR_W'($urandom_range(1, 31)); wb_data = $urandom;
      ld_valid = 1; ld_rd = 5'd12; ld_data = $urandom;
      sample();
      if (ld_ready === 1'b1 && first_ld == 0) first_ld = c;
      n_checks++; if (ld_ready !== e_ld || wb_ready !== e_wb) begin n_fail++;
        $display("FAIL starve_ready c=%0d got wb=%b ld=%b exp wb=%b ld=%b", c, wb_ready, ld_ready, e_wb, e_ld); end
      if (c == 5) begin
        n_checks++; if (arb_state !== ARB_BOOST) begin n_fail++;
          $display("FAIL starve_boost got state=%0d exp=%0d", arb_state, ARB_BOOST); end
      end
      if (c == 6) begin
        n_checks++; if (arb_state !== ARB_NORMAL || wb_ready !== 1'b1) begin n_fail++;
          $display("FAIL starve_return got state=%0d wb=%b exp state=0 wb=1", arb_state, wb_ready); end
      end
      advance();
    end
    n_checks++; if (first_ld != 5) begin n_fail++;
      $display("FAIL starve_grant_cycle got=%0d exp=5", first_ld); end
    idle_inputs();
    sample();
    advance();
  endtask

  task automatic test_scoreboard();
    ld_issue = 1; ld_issue_rd = 7; rs1_addr = 7;
    sample();
    n_checks++; if (stall !== 1'b0) begin n_fail++;
      $display("FAIL sb_no_bypass got stall=%b exp=0", stall); end
    advance();
    ld_issue = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      n_checks++; if (stall !== 1'b1 || busy[7] !== 1'b1) begin n_fail++;
        $display("FAIL sb_pending i=%0d got stall=%b busy7=%b exp 1/1", i, stall, busy[7]); end
      advance();
    end
    ld_valid = 1; ld_rd = 7; ld_data = 32'hcafe_0007;
    sample();
    n_checks++; if (ld_ready !== 1'b1 || stall !== 1'b1) begin n_fail++;
      $display("FAIL sb_grant got ld_ready=%b stall=%b exp 1/1", ld_ready, stall); end
    advance();
    ld_valid = 0;
    sample();
    n_checks++; if (stall !== 1'b0 || rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin n_fail++;
      $display("FAIL sb_cleared got stall=%b wen=%b addr=%0d exp 0/1/7", stall, rf_wen, rf_waddr); end
    advance();
    idle_inputs();
  endtask

  task automatic test_same_cycle_set_clear();
    ld_issue = 1; ld_issue_rd = 9;
    sample(); advance();
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    sample();
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++;
      $display("FAIL setclr_grant got ld_ready=%b exp=1", ld_ready); end
    advance();
    idle_inputs();
    sample();
    n_checks++; if (busy[9] !== 1'b1) begin n_fail++;
      $display("FAIL setclr_set_wins got busy9=%b exp=1", busy[9]); end
    advance();
    ld_valid = 1; ld_rd = 9;
    sample(); advance();
    idle_inputs();
    sample();
    n_checks++; if (busy[9] !== 1'b0) begin n_fail++;
      $display("FAIL setclr_release got busy9=%b exp=0", busy[9]); end
    advance();
  endtask

  task automatic test_rd_zero();
    wb_valid = 1; wb_rd = 0; wb_data = 32'h0000_00ff;
    sample();
    n_checks++; if (wb_ready !== 1'b1) begin n_fail++;
      $display("FAIL rd0_ready got=%b exp=1", wb_ready); end
    advance();
    idle_inputs();
    ld_issue = 1; ld_issue_rd = 0;
    sample();
    n_checks++; if (rf_wen !== 1'b0) begin n_fail++;
      $display("FAIL rd0_no_write got wen=%b exp=0", rf_wen); end
    advance();
    idle_inputs();
    sample();
    n_checks++; if (busy[0] !== 1'b0 || stall !== 1'b0) begin n_fail++;
      $display("FAIL rd0_busy got busy0=%b stall=%b exp 0/0", busy[0], stall); end
    advance();
  endtask

  task automatic test_reset_midflight();
    wb_valid = 1; wb_rd = 3; wb_data = 32'h3333;
    sample(); advance();
    wb_rd = 4; wb_data = 32'h4444;
    #1;
    n_checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3) begin n_fail++;
      $display("FAIL midrst_pre got wen=%b addr=%0d exp 1/3", rf_wen, rf_waddr); end
    reset_n = 0;
    #1;
    n_checks++; if (rf_wen !== 1'b0 || wb_ready !== 1'b0) begin n_fail++;
      $display("FAIL midrst_async got wen=%b wb_ready=%b exp 0/0", rf_wen, wb_ready); end
    idle_inputs();
    @(negedge clock);
    reset_n = 1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      sample();
      n_checks++; if (rf_wen !== 1'b0) begin n_fail++;
        $display("FAIL midrst_after i=%0d got wen=%b exp=0", i, rf_wen); end
      advance();
    end
  endtask

  task automatic test_dbg_port();
    dbg_valid = 1; dbg_rd = 11; dbg_data = 32'hdb9;
    sample();
    n_checks++; if (dbg_ready !== e_dbg) begin n_fail++;
      $display("FAIL dbg_ready got=%b exp=%b", dbg_ready, e_dbg); end
    advance();
    idle_inputs();
    sample();
    n_checks++; if (rf_wen !== e_prev[W-1]) begin n_fail++;
      $display("FAIL dbg_write got wen=%b exp=%b", rf_wen, e_prev[W-1]); end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wb_valid    = ($urandom_range(0, 99) < 50);
      ld_valid    = ($urandom_range(0, 99) < 60);
      dbg_valid   = ($urandom_range(0, 99) < 30);
      wb_rd       = REG_ADDR_W'($urandom_range(0, 31));
      ld_rd       = REG_ADDR_W'($urandom_range(0, 15));
      dbg_rd      = REG_ADDR_W'($urandom_range(0, 31));
      wb_data     = $urandom; ld_data = $urandom; dbg_data = $urandom;
      ld_issue    = ($urandom_range(0, 99) < 25);
      ld_issue_rd = REG_ADDR_W'($urandom_range(0, 15));
      rs1_addr    = REG_ADDR_W'($urandom_range(0, 15));
      rs2_addr    = REG_ADDR_W'($urandom_range(0, 15));
      sample();
      n_checks++; if ({wb_ready, ld_ready, dbg_ready} !== {e_wb, e_ld, e_dbg}) begin n_fail++;
        $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, {wb_ready, ld_ready, dbg_ready}, {e_wb, e_ld, e_dbg}); end
      n_checks++; if (stall !== e_stall || busy !== m_busy) begin n_fail++;
        $display("FAIL rnd_sb i=%0d got stall=%b busy=%h exp stall=%b busy=%h", i, stall, busy, e_stall, m_busy); end
      n_checks++; if (arb_state !== (m_boost ? ARB_BOOST : ARB_NORMAL)) begin n_fail++;
        $display("FAIL rnd_state i=%0d got=%0d exp=%0d", i, arb_state, m_boost); end
      n_checks++; if (rf_wen !== e_prev[W-1] ||
                      (e_prev[W-1] && {rf_waddr, rf_wdata} !== e_prev[W-2:0])) begin n_fail++;
        $display("FAIL rnd_write i=%0d got wen=%b addr=%0d data=%h exp %b/%0d/%h", i, rf_wen,
                 rf_waddr, rf_wdata, e_prev[W-1], e_prev[W-2 -: REG_ADDR_W], e_prev[XLEN-1:0]); end
      advance();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_priority();
    test_starvation();
    test_scoreboard();
    test_same_cycle_set_clear();
    test_rd_zero();
    test_reset_midflight();
    test_dbg_port();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
